// File: rtl/mem_page_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_page_reader_pkg
// Description : Shared memory constants, entry-count width, FSM state
//               encoding and the address-width helper for the page reader.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_page_reader_pkg;

    localparam int MEM_RAM_WIDTH = 18;
    localparam int MEM_RAM_DEPTH = 1024;
    localparam int MEM_NPAGE     = 8;
    localparam int NENT_W        = 8;
    localparam int PAGE_W        = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Ceiling log2, used for the memory address width
    function automatic int clogb2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_reader_fifo
// Description : Small synchronous FIFO with first-word-fall-through head
//               and occupancy output. Writes to a full FIFO and reads from
//               an empty FIFO are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_reader_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         rd_en_i,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q;
    logic [PTRW-1:0]  rd_ptr_q;
    logic [CNTW-1:0]  count_q;
    logic             w_wr;
    logic             w_rd;

    assign w_wr      = wr_en_i && (count_q != CNTW'(DEPTH));
    assign w_rd      = rd_en_i && (count_q != '0);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

    // Storage is reset so the head reads as zero after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer and occupancy bookkeeping, pointers wrap at DEPTH-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_wr) begin
                wr_ptr_q <= (wr_ptr_q == PTRW'(DEPTH - 1)) ? '0 : wr_ptr_q + PTRW'(1);
            end
            if (w_rd) begin
                rd_ptr_q <= (rd_ptr_q == PTRW'(DEPTH - 1)) ? '0 : rd_ptr_q + PTRW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_page_reader.sv
`default_nettype none
// ============================================================================
// Module      : mem_page_reader
// Description : Sweeps the selected pages of a paged block RAM, issuing one
//               read per entry, and streams the returned words with their
//               page tag through a credit-guarded output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_page_reader
    import mem_page_reader_pkg::*;
#(
    parameter int RAM_WIDTH  = MEM_RAM_WIDTH,
    parameter int RAM_DEPTH  = MEM_RAM_DEPTH,
    parameter int NPAGE      = MEM_NPAGE,
    parameter int RD_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NPAGE-1:0]              page_mask,
    input  logic [NENT_W*NPAGE-1:0]       nent_i,
    output logic [clogb2(RAM_DEPTH)-1:0]  addrb,
    output logic                          enb,
    output logic                          regceb,
    output logic                          rstb,
    input  logic [RAM_WIDTH-1:0]          doutb,
    output logic [RAM_WIDTH-1:0]          dout,
    output logic [PAGE_W-1:0]             dout_page,
    output logic                          dout_last,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          busy,
    output logic                          done
);

    localparam int AW         = clogb2(RAM_DEPTH);
    localparam int PD         = RAM_DEPTH / NPAGE;
    localparam int CW         = clogb2(PD + 1);
    localparam int FIFO_DEPTH = RD_LATENCY + 2;
    localparam int FIFO_W     = RAM_WIDTH + PAGE_W + 1;
    localparam int FIFO_CNTW  = $clog2(FIFO_DEPTH + 1);

    state_e              state_q, state_d;
    logic [NPAGE-1:0]    pend_q;
    logic [CW-1:0]       cnt_q   [NPAGE];
    logic [PAGE_W-1:0]   page_q;
    logic [CW-1:0]       len_q;
    logic [CW-1:0]       idx_q;
    logic                lastpg_q;

    logic [RD_LATENCY-1:0] pvld_q;
    logic [RD_LATENCY-1:0] plast_q;
    logic [PAGE_W-1:0]     ppage_q [RD_LATENCY];

    logic [CW-1:0]         w_clamp [NPAGE];
    logic                  w_found;
    logic [PAGE_W-1:0]     w_sel;
    logic [NPAGE-1:0]      w_pend_rest;
    int                    w_inflight;
    logic                  w_credit;
    logic                  w_issue;
    logic                  w_last_idx;
    logic                  w_drained;
    logic [FIFO_W-1:0]     w_fifo_rd;
    logic                  w_fifo_empty;
    logic [FIFO_CNTW-1:0]  w_fifo_count;

    // Per-page entry counts saturated to the page size
    always_comb begin
        for (int i = 0; i < NPAGE; i++) begin
            w_clamp[i] = (int'(nent_i[i*NENT_W +: NENT_W]) > PD)
                       ? CW'(PD) : CW'(nent_i[i*NENT_W +: NENT_W]);
        end
    end

    // Lowest pending page; pending only ever holds masked pages with entries
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = NPAGE - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                w_found = 1'b1;
                w_sel   = PAGE_W'(i);
            end
        end
        w_pend_rest = pend_q & ~(NPAGE'(1) << w_sel);
    end

    // Reads still travelling through the memory pipeline
    always_comb begin
        w_inflight = 0;
        for (int k = 0; k < RD_LATENCY; k++) begin
            w_inflight = w_inflight + int'(pvld_q[k]);
        end
    end

    // Issue only when the FIFO has room for everything already in flight
    assign w_credit   = (int'(w_fifo_count) + w_inflight) < FIFO_DEPTH;
    assign w_issue    = (state_q == ST_READ) && w_credit;
    assign w_last_idx = (idx_q == len_q - CW'(1));
    assign w_drained  = (w_inflight == 0) && w_fifo_empty;

    assign addrb  = AW'(int'(page_q) * PD + int'(idx_q));
    assign enb    = w_issue;
    assign regceb = 1'b1;
    assign rstb   = 1'b0;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DRAIN) && w_drained;

    // Sweep sequencing: start is only honoured from IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)                  state_d = ST_SCAN;
            ST_SCAN:  state_d = w_found ? ST_READ : ST_DRAIN;
            ST_READ:  if (w_issue && w_last_idx)  state_d = ST_SCAN;
            ST_DRAIN: if (w_drained)              state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sweep context: latched request, current page and entry index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= '0;
            page_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            lastpg_q <= 1'b0;
            for (int i = 0; i < NPAGE; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NPAGE; i++) begin
                            cnt_q[i]  <= w_clamp[i];
                            pend_q[i] <= page_mask[i] && (w_clamp[i] != '0);
                        end
                    end
                end
                ST_SCAN: begin
                    if (w_found) begin
                        page_q   <= w_sel;
                        len_q    <= cnt_q[w_sel];
                        idx_q    <= '0;
                        lastpg_q <= (w_pend_rest == '0);
                        pend_q   <= w_pend_rest;
                    end
                end
                ST_READ: begin
                    if (w_issue) begin
                        idx_q <= idx_q + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read-latency pipeline carrying valid, page tag and end-of-sweep flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pvld_q  <= '0;
            plast_q <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                ppage_q[k] <= '0;
            end
        end else begin
            pvld_q[0]  <= w_issue;
            plast_q[0] <= w_issue && lastpg_q && w_last_idx;
            ppage_q[0] <= page_q;
            for (int k = 1; k < RD_LATENCY; k++) begin
                pvld_q[k]  <= pvld_q[k-1];
                plast_q[k] <= plast_q[k-1];
                ppage_q[k] <= ppage_q[k-1];
            end
        end
    end

    mem_reader_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (pvld_q[RD_LATENCY-1]),
        .wr_data_i ({plast_q[RD_LATENCY-1], ppage_q[RD_LATENCY-1], doutb}),
        .rd_en_i   (dout_ready),
        .rd_data_o (w_fifo_rd),
        .empty_o   (w_fifo_empty),
        .count_o   (w_fifo_count)
    );

    assign {dout_last, dout_page, dout} = w_fifo_rd;
    assign dout_valid = !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_mem_page_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_page_reader
// Description : Scoreboard bench for mem_page_reader with a two-cycle
//               block-RAM model and directed sweeps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_page_reader;
    import mem_page_reader_pkg::*;

    localparam int RW  = 18;
    localparam int AW  = 10;
    localparam int NP  = 8;
    localparam int LAT = 2;

    typedef struct packed {
        logic [RW-1:0] data;
        logic [2:0]    page;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NP-1:0] page_mask;
    logic [8*NP-1:0] nent_i;
    logic [AW-1:0] addrb;
    logic          enb, regceb, rstb;
    logic [RW-1:0] doutb;
    logic [RW-1:0] dout;
    logic [2:0]    dout_page;
    logic          dout_last, dout_valid, dout_ready, busy, done;

    logic [RW-1:0] mem_r1, mem_r2;

    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];

    int n_checks = 0;
    int n_err    = 0;
    int n_done   = 0;
    int n_enb    = 0;
    int n_valid  = 0;
    bit stall    = 0;
    logic [RW+3:0] held;

    always #5 clk = ~clk;

    mem_page_reader #(
        .RAM_WIDTH  (RW),
        .RAM_DEPTH  (1024),
        .NPAGE      (NP),
        .RD_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .page_mask  (page_mask),
        .nent_i     (nent_i),
        .addrb      (addrb),
        .enb        (enb),
        .regceb     (regceb),
        .rstb       (rstb),
        .doutb      (doutb),
        .dout       (dout),
        .dout_page  (dout_page),
        .dout_last  (dout_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [RW-1:0] memfn(input logic [AW-1:0] a);
        return {a, 8'h00} ^ {8'h00, a} ^ 18'h15A5A;
    endfunction

    // Block RAM with output register: data appears two cycles after enb
    always @(posedge clk) begin
        if (enb) mem_r1 <= memfn(addrb);
        mem_r2 <= mem_r1;
    end
    assign doutb = mem_r2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_rd(input int addr, input int page, input bit last);
        exp_t e;
        e.data = memfn(AW'(addr));
        e.page = 3'(page);
        e.last = last;
        addr_q.push_back(AW'(addr));
        exp_q.push_back(e);
    endtask

    // Monitor: address scoreboard, output scoreboard, stall stability
    always @(negedge clk) begin
        exp_t e;
        logic [AW-1:0] a;
        if (!rst_n) begin
            stall = 0;
        end else begin
            if (enb) begin
                n_enb++;
                if (addr_q.size() == 0) begin
                    chk("unexpected_enb_addr", {22'h0, addrb}, 32'hFFFF_FFFF);
                end else begin
                    a = addr_q.pop_front();
                    chk("addrb", {22'h0, addrb}, {22'h0, a});
                end
            end
            if (stall && dout_valid) begin
                chk("stall_hold", {10'h0, dout, dout_page, dout_last}, {10'h0, held});
            end
            if (dout_valid) n_valid++;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_dout", {14'h0, dout}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout", {14'h0, dout}, {14'h0, e.data});
                    chk("dout_page", {29'h0, dout_page}, {29'h0, e.page});
                    chk("dout_last", {31'h0, dout_last}, {31'h0, e.last});
                end
            end
            stall = dout_valid && !dout_ready;
            held  = {dout, dout_page, dout_last};
            if (done) n_done++;
        end
    end

    task automatic run_sweep(input logic [7:0] mask, input logic [63:0] nent, input int budget,
                             input bit toggle, input bit coincide, input string tag);
        int   d0;
        bit   seen;
        logic [3:0] pat;
        pat  = 4'b1001;
        d0   = n_done;
        seen = 0;
        @(posedge clk); #1;
        page_mask = mask;
        nent_i    = nent;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge clk); #1;
            if (toggle) dout_ready = pat[c % 4];
            @(negedge clk);
            if (done) seen = 1;
        end
        chk({tag, "_done_in_time"}, {31'h0, seen}, 32'd1);
        if (coincide && seen) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_idle_busy"}, {31'h0, busy}, 32'd0);
        chk({tag, "_done_count"}, n_done - d0, 32'd1);
        chk({tag, "_exp_left"}, exp_q.size(), 32'd0);
        chk({tag, "_addr_left"}, addr_q.size(), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addrb"},      {22'h0, addrb}, 32'd0);
        chk({tag, "_enb"},        {31'h0, enb}, 32'd0);
        chk({tag, "_dout_valid"}, {31'h0, dout_valid}, 32'd0);
        chk({tag, "_dout_last"},  {31'h0, dout_last}, 32'd0);
        chk({tag, "_busy"},       {31'h0, busy}, 32'd0);
        chk({tag, "_done"},       {31'h0, done}, 32'd0);
        chk({tag, "_dout"},       {14'h0, dout}, 32'd0);
        chk({tag, "_dout_page"},  {29'h0, dout_page}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] n;
        int e0, v0;

        rst_n      = 1'b0;
        start      = 1'b0;
        page_mask  = '0;
        nent_i     = '0;
        dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        chk("por_regceb", {31'h0, regceb}, 32'd1);
        chk("por_rstb",   {31'h0, rstb},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single page, three entries
        expect_rd(0, 0, 0); expect_rd(1, 0, 0); expect_rd(2, 0, 1);
        n = '0; n[7:0] = 8'd3;
        run_sweep(8'h01, n, 3 + LAT + NP + 3, 0, 0, "p0x3");

        // Pages 2 and 7, page 0 has entries but is masked off; start on done is ignored
        expect_rd(256, 2, 0); expect_rd(257, 2, 0); expect_rd(896, 7, 1);
        n = '0; n[7:0] = 8'd4; n[23:16] = 8'd2; n[63:56] = 8'd1;
        run_sweep(8'h84, n, 3 + LAT + NP + 3, 0, 1, "p2p7");

        // Backpressure with ready pattern 1-0-0-1
        for (int i = 0; i < 5; i++) expect_rd(i, 0, i == 4);
        n = '0; n[7:0] = 8'd5;
        run_sweep(8'h01, n, 60, 1, 0, "stall");

        // All pages selected, every count zero
        e0 = n_enb; v0 = n_valid;
        n = '0;
        run_sweep(8'hFF, n, 4, 0, 0, "zero");
        chk("zero_no_enb",   n_enb - e0,   32'd0);
        chk("zero_no_valid", n_valid - v0, 32'd0);

        // Count above page size saturates to 128
        e0 = n_enb;
        for (int i = 0; i < 128; i++) expect_rd(384 + i, 3, i == 127);
        n = {8{8'd9}}; n[31:24] = 8'd200;
        run_sweep(8'h08, n, 128 + LAT + NP + 3, 0, 0, "clamp");
        chk("clamp_reads", n_enb - e0, 32'd128);

        // Reset in the middle of an eight-entry page
        for (int i = 0; i < 8; i++) expect_rd(i, 0, i == 7);
        n = '0; n[7:0] = 8'd8;
        @(posedge clk); #1;
        page_mask = 8'h01; nent_i = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk); #2;
        rst_n = 1'b1;
        exp_q.delete();
        addr_q.delete();
        e0 = n_enb; v0 = n_valid;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_valid", n_valid - v0, 32'd0);
        chk("midrst_no_enb",   n_enb - e0,   32'd0);
        chk("midrst_busy",     {31'h0, busy}, 32'd0);

        // Recovery sweep after the abandoned one
        expect_rd(640, 5, 0); expect_rd(641, 5, 1);
        n = '0; n[47:40] = 8'd2;
        run_sweep(8'h20, n, 2 + LAT + NP + 3, 0, 0, "recover");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
